// File: rtl/prog_loader_if.sv
// Host byte stream, program-memory write port and CPU hold/status lines of the program loader.
// master = host/memory side, slave = loader.
interface prog_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_ack;
  logic       cpu_halt;
  logic       busy;
  logic       load_done;
  logic       load_error;

  modport master (
    output rx_data, rx_valid, mem_ack,
    input  rx_ready, mem_addr, mem_wdata, mem_we, cpu_halt, busy, load_done, load_error
  );

  modport slave (
    input  rx_data, rx_valid, mem_ack,
    output rx_ready, mem_addr, mem_wdata, mem_we, cpu_halt, busy, load_done, load_error
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses SYNC, ADDR, LEN, data..., CSUM frames from the host byte stream and
// issues sequential program-memory writes while holding the CPU halted.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic          clock,
  input logic          reset,
  prog_loader_if.slave bus
);

  localparam int unsigned TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          TimeoutEn  = (TIMEOUT != 0);
  localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StWrite,
    StCsum,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [8:0]    count_q, count_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic          halt_q, halt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic ready_state;
  logic timed;
  logic accept;
  logic tmo_hit;

  assign ready_state = (state_q != StWrite) && (state_q != StDone);
  assign timed       = (state_q == StAddr) || (state_q == StLen) ||
                       (state_q == StData) || (state_q == StCsum);
  assign accept      = bus.rx_valid && ready_state;
  assign tmo_hit     = TimeoutEn && timed && !accept && (tmo_q == TmoLast);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    csum_d  = csum_q;
    tmo_d   = '0;
    we_d    = we_q;
    halt_d  = halt_q;
    done_d  = 1'b0;
    err_d   = err_q;

    // Idle-cycle counter only runs while waiting for a host byte inside a frame.
    if (timed && !accept) begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          state_d = StAddr;
          err_d   = 1'b0;
          halt_d  = 1'b1;
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d  = bus.rx_data;
          state_d = StLen;
        end
      end
      StLen: begin
        if (accept) begin
          count_d = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          csum_d  = 8'h00;
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          wdata_d = bus.rx_data;
          csum_d  = csum_q + bus.rx_data;
          we_d    = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (bus.mem_ack) begin
          we_d    = 1'b0;
          addr_d  = addr_q + 8'd1;
          count_d = count_q - 9'd1;
          state_d = (count_q == 9'd1) ? StCsum : StData;
        end
      end
      StCsum: begin
        if (accept) begin
          if (bus.rx_data == csum_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            halt_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        halt_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (tmo_hit) begin
      err_d   = 1'b1;
      halt_d  = 1'b0;
      tmo_d   = '0;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      count_q <= 9'd0;
      csum_q  <= 8'h00;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Gated by reset so nothing is offered to the host while held in reset.
  assign bus.rx_ready   = ready_state && !reset;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = we_q;
  assign bus.cpu_halt   = halt_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.load_done  = done_q;
  assign bus.load_error = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued by the stimulus and
// popped by a monitor on every committed write; status outputs are checked inline.
module tb_prog_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  int   ack_delay = 1;
  int   we_cycles = 0;
  logic [15:0] exp_q[$];

  prog_loader_if bus ();

  prog_loader #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Memory model: acks after mem_we has been high for ack_delay cycles.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clock);
      bus.mem_ack = 1'b0;
      if (bus.mem_we) begin
        if (we_cycles >= ack_delay) begin
          bus.mem_ack = 1'b1;
          we_cycles   = 0;
        end else begin
          we_cycles++;
        end
      end else begin
        we_cycles = 0;
      end
    end
  end

  // Write monitor / scoreboard.
  always @(posedge clock) begin
    if (bus.load_done) done_cnt++;
    if (bus.mem_we && bus.mem_ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected got=[%h]=%h expected=none", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          bad++;
          $display("FAIL write got=[%h]=%h expected=[%h]=%h",
                   bus.mem_addr, bus.mem_wdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Returns 1 time unit after the posedge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clock);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.rx_ready) begin
      total++;
      bad++;
      $display("FAIL send_stuck got=rx_ready 0 expected=rx_ready 1 byte=%h", b);
    end
    @(posedge clock);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int d0;
    logic ok;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset state
    #12;
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_outputs", {bus.mem_we, bus.cpu_halt, bus.busy, bus.load_done, bus.load_error}, 0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("rel_rx_ready", bus.rx_ready, 1);

    // Happy path
    d0 = done_cnt;
    exp_q.push_back(16'h1011);
    exp_q.push_back(16'h1122);
    exp_q.push_back(16'h1233);
    send_byte(8'hA5);
    check("happy_halt_after_sync", {bus.cpu_halt, bus.busy}, 2'b11);
    send_byte(8'h10);
    send_byte(8'h03);
    send_byte(8'h11);
    check("happy_we_next_cycle", {bus.mem_we, bus.rx_ready, bus.mem_addr, bus.mem_wdata},
          {1'b1, 1'b0, 8'h10, 8'h11});
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h66);
    check("happy_done_cycle", {bus.load_done, bus.cpu_halt, bus.busy, bus.rx_ready}, 4'b1110);
    tick(1);
    check("happy_after_done", {bus.load_done, bus.cpu_halt, bus.busy, bus.load_error}, 0);
    check("happy_done_count", done_cnt - d0, 1);
    check("happy_writes_left", exp_q.size(), 0);

    // Length 0 (256 bytes) with address wrap
    d0 = done_cnt;
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(8'hFE + i), 8'h01});
    send_byte(8'hA5);
    send_byte(8'hFE);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'h01);
    send_byte(8'h00);
    check("wrap_done", bus.load_done, 1);
    tick(1);
    check("wrap_done_count", done_cnt - d0, 1);
    check("wrap_writes_left", exp_q.size(), 0);
    check("wrap_idle", {bus.busy, bus.cpu_halt, bus.load_error}, 0);

    // Bad checksum
    d0 = done_cnt;
    exp_q.push_back(16'h007F);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h7F);
    send_byte(8'h80);
    check("badcs_error", {bus.load_error, bus.cpu_halt, bus.busy, bus.load_done}, 4'b1000);
    tick(3);
    check("badcs_sticky", bus.load_error, 1);
    check("badcs_no_done", done_cnt - d0, 0);
    check("badcs_writes_left", exp_q.size(), 0);
    send_byte(8'hA5);
    check("sync_clears_error", {bus.load_error, bus.cpu_halt}, 2'b01);

    // Timeout: frame continues with ADDR then goes silent
    send_byte(8'h20);
    tick(15);
    check("tmo_not_yet", {bus.load_error, bus.cpu_halt, bus.busy}, 3'b011);
    tick(1);
    check("tmo_fired", {bus.load_error, bus.cpu_halt, bus.busy}, 3'b100);

    // Garbage before SYNC, then a long ack stall
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_ignored", {bus.busy, bus.cpu_halt, bus.load_error}, 3'b001);
    d0 = done_cnt;
    ack_delay = 50;
    exp_q.push_back(16'h305A);
    send_byte(8'hA5);
    check("garbage_sync_clears", bus.load_error, 0);
    send_byte(8'h30);
    send_byte(8'h01);
    send_byte(8'h5A);
    ok = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (!(bus.mem_we && !bus.rx_ready && bus.mem_addr == 8'h30 && bus.mem_wdata == 8'h5A &&
            !bus.load_error && bus.busy))
        ok = 1'b0;
    end
    check("stall_stable", ok, 1);
    send_byte(8'h5A);
    check("stall_done", {bus.load_done, bus.load_error}, 2'b10);
    tick(1);
    check("stall_writes_left", exp_q.size(), 0);
    check("stall_done_count", done_cnt - d0, 1);

    // Async reset during WRITE, then a fresh frame
    ack_delay = 1000;
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'h02);
    send_byte(8'hAA);
    check("pre_reset_write", bus.mem_we, 1);
    #2 reset = 1'b1;
    #1 check("reset_mid_write", {bus.mem_we, bus.cpu_halt, bus.busy}, 0);
    @(negedge clock);
    reset = 1'b0;
    ack_delay = 1;
    d0 = done_cnt;
    exp_q.push_back(16'h40AA);
    exp_q.push_back(16'h41BB);
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'h65);
    check("after_reset_done", bus.load_done, 1);
    tick(1);
    check("after_reset_writes_left", exp_q.size(), 0);
    check("after_reset_done_count", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
